ram_bist_ctrl: RTL and testbench

Initiator-side controller that drives the 32x32 synchronous `ram` block's port set (ena, wena, addr, data_in, data_out) as a built-in self test.
- On a start pulse it writes a seed-derived pattern to every word.
- It then reads every word back and compares each against the expected value.
- It reports pass/fail, the error count and the first failing address.
- It sits between the lab top level (button/switch inputs, LED/seven-segment outputs) and one `ram` instance.

---
 rtl/ram_bist_ctrl_if.sv | 14 +
 rtl/ram_bist_ctrl.sv | 103 ++++++++++
 tb/tb_ram_bist_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bist_ctrl_if.sv
// ram_bist_ctrl_if: memory port bundle between the BIST controller and one ram instance.
interface ram_bist_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              mem_ena;
    logic              mem_wena;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_ena, mem_wena, mem_addr, mem_wdata, input mem_rdata);
    modport slave  (input mem_ena, mem_wena, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: writes seed+addr to every word, reads all back, reports pass/err_count/first_err_addr.
module ram_bist_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   seed,
    ram_bist_ctrl_if.master     bus,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [5:0]          err_count,
    output logic [ADDR_W-1:0]   first_err_addr
);
    typedef enum logic [2:0] {IDLE, WR, RD, LAST, DONE} state_t;

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [5:0]        ERR_MAX  = 6'(DEPTH);

    state_t            state, state_n;
    logic [DATA_W-1:0] seed_q;
    logic [ADDR_W-1:0] addr_inc, cmp_addr;
    logic [DATA_W-1:0] exp_rd;
    logic              at_max, cmp_en, mism;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start  ? WR   : IDLE;
            WR:      state_n = at_max ? RD   : WR;
            RD:      state_n = at_max ? LAST : RD;
            LAST:    state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // Read data lags the presented address by one edge; the first RD edge has nothing to check.
    always_comb begin
        at_max   = bus.mem_addr == MAX_ADDR;
        addr_inc = bus.mem_addr + ADDR_W'(1);
        cmp_en   = (state == RD && bus.mem_addr != '0) || state == LAST;
        cmp_addr = state == LAST ? MAX_ADDR : bus.mem_addr - ADDR_W'(1);
        exp_rd   = seed_q + DATA_W'(cmp_addr);
        mism     = cmp_en && (bus.mem_rdata !== exp_rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_q         <= '0;
            bus.mem_ena    <= 1'b0;
            bus.mem_wena   <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            done <= 1'b0;
            if (mism) begin
                if (err_count == '0)     first_err_addr <= cmp_addr;
                if (err_count != ERR_MAX) err_count     <= err_count + 6'd1;
            end
            case (state)
                IDLE: if (start) begin
                    seed_q         <= seed;
                    err_count      <= '0;
                    first_err_addr <= '0;
                    pass           <= 1'b0;
                    busy           <= 1'b1;
                    bus.mem_ena    <= 1'b1;
                    bus.mem_wena   <= 1'b1;
                    bus.mem_addr   <= '0;
                    bus.mem_wdata  <= seed;
                end
                WR: if (at_max) begin
                    bus.mem_wena <= 1'b0;
                    bus.mem_addr <= '0;
                end else begin
                    bus.mem_addr  <= addr_inc;
                    bus.mem_wdata <= seed_q + DATA_W'(addr_inc);
                end
                RD: if (at_max) bus.mem_ena  <= 1'b0;
                    else        bus.mem_addr <= addr_inc;
                LAST: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= err_count == '0 && !mism;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: drives BIST runs against a behavioural ram with optional stuck-at faults.
module tb_ram_bist_ctrl;
    logic        clk = 0, rst = 1, start = 0, fault = 0;
    logic [31:0] seed = 0;
    logic        busy, done, pass;
    logic [5:0]  err_count;
    logic [4:0]  first_err_addr;
    int          errors = 0, checks = 0, n_wr = 0;
    logic [36:0] wq[$];
    logic [11:0] rq[$];
    logic [36:0] wexp;
    logic [11:0] rexp;
    logic [31:0] ram_mem [32];

    ram_bist_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus();

    ram_bist_ctrl #(.ADDR_W(5), .DATA_W(32), .DEPTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .bus(bus),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    // Behavioural ram: one-cycle read latency, garbage outside read cycles, optional bit-3 stuck-at-1 at 7 and 20.
    always @(posedge clk) begin
        if (bus.mem_ena && bus.mem_wena) begin
            ram_mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= 32'hDEAD_BEEF;
        end else if (bus.mem_ena)
            bus.mem_rdata <= ram_mem[bus.mem_addr] |
                ((fault && (bus.mem_addr == 5'd7 || bus.mem_addr == 5'd20)) ? 32'h8 : 32'h0);
        else
            bus.mem_rdata <= 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        if (bus.mem_wena) begin
            n_wr++;
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected addr=%0d data=%h", bus.mem_addr, bus.mem_wdata);
            end else begin
                wexp = wq.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== wexp || bus.mem_ena !== 1'b1) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%h ena=%b want addr=%0d data=%h ena=1",
                             bus.mem_addr, bus.mem_wdata, bus.mem_ena, wexp[36:32], wexp[31:0]);
                end
            end
        end
        if (done) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected pass=%b err=%0d first=%0d", pass, err_count, first_err_addr);
            end else begin
                rexp = rq.pop_front();
                if ({pass, err_count, first_err_addr} !== rexp) begin
                    errors++;
                    $display("FAIL result got pass=%b err=%0d first=%0d want pass=%b err=%0d first=%0d",
                             pass, err_count, first_err_addr, rexp[11], rexp[10:5], rexp[4:0]);
                end
            end
        end
    end

    task automatic expect_test(input logic [31:0] s, input logic p, input logic [5:0] e, input logic [4:0] f);
        for (int i = 0; i < 32; i++) wq.push_back({5'(i), s + 32'(i)});
        rq.push_back({p, e, f});
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.mem_ena, bus.mem_wena, bus.mem_addr, bus.mem_wdata, busy, done, pass, err_count, first_err_addr} !== '0) begin
            errors++;
            $display("FAIL reset_state ena=%b wena=%b addr=%0d wdata=%h busy=%b done=%b pass=%b err=%0d first=%0d want all 0",
                     bus.mem_ena, bus.mem_wena, bus.mem_addr, bus.mem_wdata, busy, done, pass, err_count, first_err_addr);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic run_test(input logic [31:0] s, input logic f, input logic p, input logic [5:0] e,
                            input logic [4:0] fa, input bit repulse);
        int cyc, w0;
        fault = f;
        @(negedge clk);
        checks++;
        if (bus.mem_ena !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet ena=%b busy=%b want 0 0", bus.mem_ena, busy);
        end
        w0 = n_wr;
        seed = s;
        start = 1;
        expect_test(s, p, e, fa);
        @(negedge clk);
        start = 0;
        cyc = 0;
        checks++;
        if (busy !== 1'b1 || bus.mem_wena !== 1'b1) begin
            errors++;
            $display("FAIL accept busy=%b wena=%b want 1 1", busy, bus.mem_wena);
        end
        while (!done && cyc < 200) begin
            if (repulse && (cyc == 10 || cyc == 40)) begin
                start = 1;
                seed = ~s;
            end else start = 0;
            @(negedge clk);
            cyc++;
        end
        start = 0;
        checks++;
        if (cyc !== 65) begin
            errors++;
            $display("FAIL latency got %0d cycles want 65", cyc);
        end
        checks++;
        if (busy !== 1'b0 || bus.mem_ena !== 1'b0) begin
            errors++;
            $display("FAIL done_state busy=%b ena=%b want 0 0", busy, bus.mem_ena);
        end
        checks++;
        if (n_wr - w0 !== 32) begin
            errors++;
            $display("FAIL write_count got %0d want 32", n_wr - w0);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_held_start;
        int cyc;
        fault = 0;
        @(negedge clk);
        seed = 32'h0000_1000;
        start = 1;
        expect_test(seed, 1'b1, 6'd0, 5'd0);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!done && cyc < 200);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL held_first_done timeout after %0d cycles", cyc);
        end
        expect_test(seed, 1'b1, 6'd0, 5'd0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL held_idle busy=%b want 0", busy);
        end
        @(negedge clk);
        start = 0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL held_retrigger busy=%b want 1", busy);
        end
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!done && cyc < 200);
        checks++;
        if (cyc !== 65) begin
            errors++;
            $display("FAIL held_second_latency got %0d want 65", cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cyc, dn;
        fault = 0;
        @(negedge clk);
        seed = 32'h1234_0000;
        start = 1;
        expect_test(seed, 1'b1, 6'd0, 5'd0);
        @(negedge clk);
        start = 0;
        cyc = 0;
        while (bus.mem_addr !== 5'd12 && cyc < 50) begin @(negedge clk); cyc++; end
        checks++;
        if (bus.mem_addr !== 5'd12 || bus.mem_wena !== 1'b1) begin
            errors++;
            $display("FAIL mid_wr_reach addr=%0d wena=%b want 12 1", bus.mem_addr, bus.mem_wena);
        end
        #2 rst = 1;
        #1;
        checks++;
        if (bus.mem_ena !== 1'b0 || bus.mem_wena !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset ena=%b wena=%b busy=%b want 0 0 0", bus.mem_ena, bus.mem_wena, busy);
        end
        wq.delete();
        rq.delete();
        @(negedge clk);
        rst = 0;
        dn = 0;
        repeat (80) begin @(negedge clk); if (done) dn++; end
        checks++;
        if (dn !== 0) begin
            errors++;
            $display("FAIL reset_no_done got %0d done pulses want 0", dn);
        end
        run_test(32'hA5A5_0000, 1'b0, 1'b1, 6'd0, 5'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        run_test(32'h0000_0000, 1'b0, 1'b1, 6'd0, 5'd0, 1'b0);
        run_test(32'hFFFF_FFF0, 1'b0, 1'b1, 6'd0, 5'd0, 1'b0);
        run_test(32'h0000_0000, 1'b1, 1'b0, 6'd2, 5'd7, 1'b0);
        run_test(32'h0F0F_0003, 1'b0, 1'b1, 6'd0, 5'd0, 1'b1);
        test_held_start();
        test_reset_mid();
        checks++;
        if (wq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL leftover writes=%0d results=%0d want 0 0", wq.size(), rq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
